// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes, ALU op encodings, decode record and FSM states for the ALU command issuer.
package alu_pkg;

    localparam logic [2:0] FUNC_AND = 3'b000;
    localparam logic [2:0] FUNC_OR  = 3'b001;
    localparam logic [2:0] FUNC_ADD = 3'b010;
    localparam logic [2:0] FUNC_SUB = 3'b011;
    localparam logic [2:0] FUNC_SLT = 3'b100;
    localparam logic [2:0] FUNC_NOR = 3'b101;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       ainvert;
        logic       bnegate;
        logic [1:0] op;
        logic       illegal;
        logic       ovf_valid;
    } dec_t;

endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: maps a command function code onto ALU control lines plus illegal/overflow-meaningful flags.
module alu_func_decode
    import alu_pkg::*;
(
    input  logic [2:0] func,
    output dec_t       dec
);

    always_comb begin
        dec = '{ainvert: 1'b0, bnegate: 1'b0, op: OP_AND, illegal: 1'b1, ovf_valid: 1'b0};
        case (func)
            FUNC_AND: dec = '{1'b0, 1'b0, OP_AND, 1'b0, 1'b0};
            FUNC_OR:  dec = '{1'b0, 1'b0, OP_OR,  1'b0, 1'b0};
            FUNC_ADD: dec = '{1'b0, 1'b0, OP_ADD, 1'b0, 1'b1};
            FUNC_SUB: dec = '{1'b0, 1'b1, OP_ADD, 1'b0, 1'b1};
            FUNC_SLT: dec = '{1'b0, 1'b1, OP_SLT, 1'b0, 1'b0};
            FUNC_NOR: dec = '{1'b1, 1'b1, OP_AND, 1'b0, 1'b0};
            default:  dec = '{1'b0, 1'b0, OP_AND, 1'b1, 1'b0};
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: drives a combinational ALU from valid/ready commands, holds the drive for a settle window,
// captures the result into a valid/ready response and keeps saturating op/overflow statistics.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_func,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_ainvert,
    output logic             alu_bnegate,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state, state_n;
    dec_t       dec;
    logic [3:0] cnt;
    logic       ovf_ok;
    logic       accept, capture, rsp_done;

    alu_func_decode u_dec (
        .func (cmd_func),
        .dec  (dec)
    );

    assign accept    = cmd_valid && cmd_ready && state == IDLE;
    assign capture   = state == EXEC && cnt == 4'd1;
    assign rsp_valid = state == RESP;
    assign rsp_done  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = dec.illegal ? RESP : EXEC;
            EXEC:    if (capture) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready    <= 1'b0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_ainvert  <= 1'b0;
            alu_bnegate  <= 1'b0;
            alu_op       <= OP_AND;
            cnt          <= 4'd0;
            ovf_ok       <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            cmd_ready <= state_n == IDLE;
            if (accept && !dec.illegal) begin
                alu_in1     <= cmd_a;
                alu_in2     <= cmd_b;
                alu_ainvert <= dec.ainvert;
                alu_bnegate <= dec.bnegate;
                alu_op      <= dec.op;
                ovf_ok      <= dec.ovf_valid;
                cnt         <= SETTLE;
            end
            if (accept && dec.illegal) begin
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_zero     <= 1'b0;
                rsp_err      <= 1'b1;
            end
            if (state == EXEC) cnt <= cnt - 4'd1;
            if (capture) begin
                rsp_result   <= alu_result;
                rsp_overflow <= alu_overflow && ovf_ok;
                rsp_zero     <= alu_zero;
                rsp_err      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (rsp_done) begin
            if (!rsp_err && !(&op_count))       op_count  <= op_count + 1'b1;
            if (rsp_overflow && !(&ovf_count))  ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: randomized and directed checks of alu_cmd_issuer paired with a 32-bit ALU model.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_func = 3'd0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        alu_ainvert, alu_bnegate, alu_overflow, alu_zero;
    logic [1:0]  alu_op;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_zero, rsp_err;
    logic [15:0] op_count, ovf_count;

    int checks = 0, failures = 0;
    int exp_ops = 0, exp_ovf = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [2:0]  last_f = 3'd0;
    logic [3:0]  ctl_tab [8];

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count), .ovf_count(ovf_count)
    );

    // 1-bit-slice style ALU: invert/negate inputs, shared adder, overflow always from the adder
    logic [31:0] aa, bb, sum;
    logic        set;
    always_comb begin
        aa = alu_ainvert ? ~alu_in1 : alu_in1;
        bb = alu_bnegate ? ~alu_in2 : alu_in2;
        sum = aa + bb + {31'd0, alu_bnegate};
        alu_overflow = (aa[31] == bb[31]) && (sum[31] != aa[31]);
        set = sum[31] ^ alu_overflow;
        alu_result = alu_op == 2'b00 ? aa & bb : alu_op == 2'b01 ? aa | bb : alu_op == 2'b10 ? sum : {31'd0, set};
        alu_zero = alu_result == 32'd0;
    end

    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic z, output logic er);
        ov = 1'b0;
        er = 1'b0;
        case (f)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd3: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: r = ~(a | b);
            default: begin r = '0; er = 1'b1; end
        endcase
        z = !er && r == 32'd0;
    endfunction

    function automatic void count_rsp(input logic ov, input logic er);
        if (!er && exp_ops < 65535) exp_ops++;
        if (ov && exp_ovf < 65535) exp_ovf++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake with rsp_ready high; lat counts edges from accept to rsp_valid
    task automatic xact(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic ov, output logic z, output logic er, output int lat);
        logic [31:0] mr;
        logic mo, mz, me;
        int n = 0;
        cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        checks++;
        if (!rsp_valid) begin failures++; $display("FAIL xact_timeout func=%0d rsp_valid=%b required=1", f, rsp_valid); end
        r = rsp_result; ov = rsp_overflow; z = rsp_zero; er = rsp_err;
        tick();
        model(f, a, b, mr, mo, mz, me);
        count_rsp(mo, me);
        if (!me) begin last_a = a; last_b = b; last_f = f; end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op, rsp_result,
             rsp_overflow, rsp_zero, rsp_err, op_count, ovf_count} !== '0) begin
            failures++; $display("FAIL reset_outputs cmd_ready=%b rsp_valid=%b alu_in1=%h op_count=%0d required all zero",
                                 cmd_ready, rsp_valid, alu_in1, op_count);
        end
        #10 rst_n = 1'b1;
        #2;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", cmd_ready); end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge got=%b exp=1", cmd_ready); end
    endtask

    typedef struct {logic [2:0] f; logic [31:0] a, b, r; logic ov, z;} vec_t;
    vec_t dv [7];

    task automatic test_directed();
        logic [31:0] r;
        logic ov, z, er;
        int lat;
        dv[0] = '{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        dv[1] = '{3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
        dv[2] = '{3'd3, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        dv[3] = '{3'd4, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
        dv[4] = '{3'd4, 32'h0FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        dv[5] = '{3'd5, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0, 1'b1};
        dv[6] = '{3'd0, 32'hFFFFFFFF, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            xact(dv[i].f, dv[i].a, dv[i].b, r, ov, z, er, lat);
            checks++;
            if ({r, ov, z, er} !== {dv[i].r, dv[i].ov, dv[i].z, 1'b0}) begin
                failures++; $display("FAIL directed_%0d result=%h ovf=%b zero=%b err=%b required %h %b %b 0",
                                     i, r, ov, z, er, dv[i].r, dv[i].ov, dv[i].z);
            end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL directed_latency_%0d got=%0d exp=1", i, lat); end
            checks++;
            if ({alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op} !== {dv[i].a, dv[i].b, ctl_tab[dv[i].f]}) begin
                failures++; $display("FAIL directed_drive_%0d in1=%h in2=%h ctl=%b required %h %h %b", i, alu_in1, alu_in2,
                                     {alu_ainvert, alu_bnegate, alu_op}, dv[i].a, dv[i].b, ctl_tab[dv[i].f]);
            end
            checks++;
            if (op_count !== 16'(exp_ops) || ovf_count !== 16'(exp_ovf)) begin
                failures++; $display("FAIL directed_counts_%0d op=%0d ovf=%0d required %0d %0d", i, op_count, ovf_count, exp_ops, exp_ovf);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] r;
        logic ov, z, er;
        int lat;
        for (int i = 6; i < 8; i++) begin
            xact(3'(i), $urandom, $urandom, r, ov, z, er, lat);
            checks++;
            if ({r, ov, z, er} !== {32'd0, 1'b0, 1'b0, 1'b1} || lat != 0) begin
                failures++; $display("FAIL illegal_%0d result=%h ovf=%b zero=%b err=%b lat=%0d required 0 0 0 1 lat 0", i, r, ov, z, er, lat);
            end
            checks++;
            if ({alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op} !== {last_a, last_b, ctl_tab[last_f]}) begin
                failures++; $display("FAIL illegal_drive_%0d in1=%h in2=%h required %h %h", i, alu_in1, alu_in2, last_a, last_b);
            end
            checks++;
            if (op_count !== 16'(exp_ops)) begin failures++; $display("FAIL illegal_opcount got=%0d exp=%0d", op_count, exp_ops); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_func = 3'd1; cmd_a = 32'h7FFFFFFE; cmd_b = 32'hA0A0A0A0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_func = 3'd0; cmd_a = 32'h12345678; cmd_b = 32'hFFFF0000;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_result, alu_in1} !== {1'b1, 1'b0, 32'hFFFFFFFE, 32'h7FFFFFFE}) begin
                failures++; $display("FAIL backpressure_hold_%0d valid=%b ready=%b result=%h in1=%h required 1 0 fffffffe 7ffffffe",
                                     i, rsp_valid, cmd_ready, rsp_result, alu_in1);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        count_rsp(1'b0, 1'b0);
        checks++;
        if ({rsp_valid, cmd_ready, alu_in1} !== {1'b0, 1'b1, 32'h7FFFFFFE} || op_count !== 16'(exp_ops)) begin
            failures++; $display("FAIL backpressure_release valid=%b ready=%b in1=%h op=%0d required 0 1 7ffffffe %0d",
                                 rsp_valid, cmd_ready, alu_in1, op_count, exp_ops);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, alu_in1} !== {1'b0, 32'h12345678}) begin
            failures++; $display("FAIL backpressure_second_accept ready=%b in1=%h required 0 12345678", cmd_ready, alu_in1);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 32'h12340000}) begin
            failures++; $display("FAIL backpressure_second_rsp valid=%b result=%h required 1 12340000", rsp_valid, rsp_result);
        end
        tick();
        count_rsp(1'b0, 1'b0);
        last_a = 32'h12345678; last_b = 32'hFFFF0000; last_f = 3'd0;
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] r;
        logic ov, z, er;
        int lat, n = 0;
        logic saw = 1'b0;
        cmd_valid = 1'b1; cmd_func = 3'd2; cmd_a = 32'h7FFFFFFF; cmd_b = 32'h7FFFFFFF;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op, rsp_result,
             rsp_overflow, rsp_zero, rsp_err, op_count, ovf_count} !== '0) begin
            failures++; $display("FAIL async_reset_outputs ready=%b valid=%b in1=%h op=%0d ovf=%0d required all zero",
                                 cmd_ready, rsp_valid, alu_in1, op_count, ovf_count);
        end
        exp_ops = 0; exp_ovf = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin saw |= rsp_valid; tick(); end
        checks++;
        if (saw !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_abandon saw_valid=%b ready=%b required 0 1", saw, cmd_ready);
        end
        xact(3'd2, 32'd5, 32'd6, r, ov, z, er, lat);
        checks++;
        if ({r, ov, z, er} !== {32'd11, 3'b000} || op_count !== 16'd1 || ovf_count !== 16'd0) begin
            failures++; $display("FAIL after_reset result=%h op=%0d ovf=%0d required 0000000b 1 0", r, op_count, ovf_count);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] r, mr, a, b;
        logic ov, z, er, mo, mz, me;
        logic [2:0] f;
        int lat;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            model(f, a, b, mr, mo, mz, me);
            xact(f, a, b, r, ov, z, er, lat);
            checks++;
            if ({r, ov, z, er} !== {mr, mo, mz, me} || lat != (me ? 0 : 1)) begin
                failures++; $display("FAIL random_%0d f=%0d a=%h b=%h result=%h ovf=%b zero=%b err=%b lat=%0d required %h %b %b %b",
                                     i, f, a, b, r, ov, z, er, lat, mr, mo, mz, me);
            end
            checks++;
            if (op_count !== 16'(exp_ops) || ovf_count !== 16'(exp_ovf) ||
                {alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op} !== {last_a, last_b, ctl_tab[last_f]}) begin
                failures++; $display("FAIL random_state_%0d op=%0d ovf=%0d in1=%h required %0d %0d %h",
                                     i, op_count, ovf_count, alu_in1, exp_ops, exp_ovf, last_a);
            end
        end
    endtask

    typedef struct {logic [31:0] r; logic ov, z;} exp_t;

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int acc[$];
        int cyc = 0, sent = 0, got = 0;
        logic pr, pv, me;
        rsp_ready = 1'b1;
        cmd_func = 3'($urandom_range(0, 5)); cmd_a = pick(); cmd_b = pick(); cmd_valid = 1'b1;
        while (got < 4 && cyc < 60) begin
            pr = cmd_ready && cmd_valid;
            pv = rsp_valid;
            if (pv && q.size() > 0) begin
                e = q.pop_front();
                got++;
                count_rsp(e.ov, 1'b0);
                checks++;
                if ({rsp_result, rsp_overflow, rsp_zero, rsp_err} !== {e.r, e.ov, e.z, 1'b0}) begin
                    failures++; $display("FAIL b2b_rsp_%0d result=%h ovf=%b zero=%b required %h %b %b",
                                         got, rsp_result, rsp_overflow, rsp_zero, e.r, e.ov, e.z);
                end
            end
            if (pr) begin
                model(cmd_func, cmd_a, cmd_b, e.r, e.ov, e.z, me);
                q.push_back(e);
            end
            tick();
            cyc++;
            if (pr) begin
                acc.push_back(cyc);
                sent++;
                if (sent == 4) cmd_valid = 1'b0;
                else begin cmd_func = 3'($urandom_range(0, 5)); cmd_a = pick(); cmd_b = pick(); end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (got != 4 || acc.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d accepted=%0d required 4 4", got, acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", i, acc[i] - acc[i-1]); end
        end
        checks++;
        if (op_count !== 16'(exp_ops)) begin failures++; $display("FAIL b2b_opcount got=%0d exp=%0d", op_count, exp_ops); end
    endtask

    initial begin
        ctl_tab[0] = 4'b0000; ctl_tab[1] = 4'b0001; ctl_tab[2] = 4'b0010; ctl_tab[3] = 4'b0110;
        ctl_tab[4] = 4'b0111; ctl_tab[5] = 4'b1100; ctl_tab[6] = 4'b0000; ctl_tab[7] = 4'b0000;
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
